// File: rtl/wb_slave_pkg.sv
// Shared register map, CTRL/STATUS bit positions and byte-lane helper for the
// Wishbone timer/LED slave.
package wb_slave_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_RELOAD  = 3'd2;
    localparam logic [2:0] REG_COUNT   = 3'd3;
    localparam logic [2:0] REG_LEDS    = 3'd4;
    localparam logic [2:0] REG_SCRATCH = 3'd5;
    localparam logic [2:0] REG_ID      = 3'd6;
    localparam logic [2:0] REG_PWM     = 3'd7;

    localparam int CTRL_ENABLE      = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;
    localparam int STATUS_EXPIRED   = 0;

    localparam logic [31:0] DEFAULT_ID_VALUE = 32'h5742_0001;

    // Merge a bus write into an existing word, one byte lane per select bit.
    function automatic logic [31:0] apply_sel(input logic [31:0] old_value,
                                              input logic [31:0] new_value,
                                              input logic [3:0]  sel);
        logic [31:0] result;
        result = old_value;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                result[i*8 +: 8] = new_value[i*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/wb_timer_led_slave_if.sv
// Pipelined Wishbone bus bundle between the master and the timer/LED slave.
interface wb_timer_led_slave_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        stall;
    logic        ack;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output cyc, stb, we, addr, wdata, sel,
        input  stall, ack, err, rdata
    );

    modport slave (
        input  cyc, stb, we, addr, wdata, sel,
        output stall, ack, err, rdata
    );
endinterface

// File: rtl/wb_timer_core.sv
// Down-counting timer: prescaler, COUNT/RELOAD registers and the expired flag.
// Bus decode lives in the top; this block only sees write strobes and merged data.
module wb_timer_core #(
    parameter int PRESCALE = 12
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        enable,
    input  logic        auto_reload,
    input  logic        reload_we,
    input  logic [31:0] reload_wdata,
    input  logic        count_we,
    input  logic [31:0] count_wdata,
    input  logic        expired_clear,
    output logic [31:0] reload,
    output logic [31:0] count,
    output logic        expired,
    output logic        oneshot_stop
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] prescaler;
    logic          prescaler_wrap;
    logic          tick;
    logic          at_zero;

    // A bus write to COUNT suppresses the tick that would land in the same cycle.
    assign prescaler_wrap = (prescaler == PRESCALE_LAST);
    assign tick           = enable & prescaler_wrap & ~count_we;
    assign at_zero        = (count == '0);
    assign oneshot_stop   = tick & at_zero & ~auto_reload;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            prescaler <= '0;
        end else if (count_we) begin
            prescaler <= '0;
        end else if (enable) begin
            prescaler <= prescaler_wrap ? '0 : prescaler + PW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            reload <= '0;
        end else if (reload_we) begin
            reload <= reload_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
        end else if (count_we) begin
            count <= count_wdata;
        end else if (tick) begin
            if (!at_zero) begin
                count <= count - 32'd1;
            end else if (auto_reload) begin
                count <= reload;
            end
        end
    end

    // Hardware set wins over a write-1-to-clear in the same cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            expired <= 1'b0;
        end else if (tick && at_zero) begin
            expired <= 1'b1;
        end else if (expired_clear) begin
            expired <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_timer_led_slave.sv
// Wishbone timer/LED/scratch/ID slave. Define WB_TIMER_LED_SLAVE_PWM_EN to add
// the PWM duty register in slot 7 that dims the LED outputs.
module wb_timer_led_slave
    import wb_slave_pkg::*;
#(
    parameter logic [29:0] BASE_ADDR = 30'h0000_0010,
    parameter int          ADDR_W    = 3,
    parameter int          PRESCALE  = 12,
    parameter logic [31:0] ID_VALUE  = DEFAULT_ID_VALUE
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    wb_timer_led_slave_if.slave  wb,
    output logic [7:0]           o_leds,
    output logic                 o_irq
);
    logic              request;
    logic              base_match;
    logic [ADDR_W-1:0] slot;
    logic              slot_mapped;
    logic              access_ok;
    logic              bus_write;
    logic [31:0]       read_value;
    logic [31:0]       merged;

    logic [2:0]        ctrl;
    logic [7:0]        leds_reg;
    logic [31:0]       scratch;
    logic              ack_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic              irq_q;

    logic [31:0]       timer_reload;
    logic [31:0]       timer_count;
    logic              timer_expired;
    logic              oneshot_stop;

`ifdef WB_TIMER_LED_SLAVE_PWM_EN
    logic [7:0]        pwm_duty;
    logic [7:0]        pwm_cnt;
`endif

    assign request    = wb.cyc & wb.stb;
    assign base_match = (wb.addr[29:ADDR_W] == BASE_ADDR[29:ADDR_W]);
    assign slot       = wb.addr[ADDR_W-1:0];

    always_comb begin
        slot_mapped = 1'b1;
        read_value  = '0;
        case (slot)
            ADDR_W'(REG_CTRL):    read_value = {29'd0, ctrl};
            ADDR_W'(REG_STATUS):  read_value = {31'd0, timer_expired};
            ADDR_W'(REG_RELOAD):  read_value = timer_reload;
            ADDR_W'(REG_COUNT):   read_value = timer_count;
            ADDR_W'(REG_LEDS):    read_value = {24'd0, leds_reg};
            ADDR_W'(REG_SCRATCH): read_value = scratch;
            ADDR_W'(REG_ID):      read_value = ID_VALUE;
`ifdef WB_TIMER_LED_SLAVE_PWM_EN
            ADDR_W'(REG_PWM):     read_value = {24'd0, pwm_duty};
`endif
            default:              slot_mapped = 1'b0;
        endcase
    end

    assign access_ok = base_match & slot_mapped & ~(wb.we & (slot == ADDR_W'(REG_ID)));
    assign bus_write = request & access_ok & wb.we;
    assign merged    = apply_sel(read_value, wb.wdata, wb.sel);

    // A CTRL write in the same cycle overrides the one-shot enable clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ctrl <= '0;
        end else if (bus_write && slot == ADDR_W'(REG_CTRL)) begin
            ctrl <= merged[2:0];
        end else if (oneshot_stop) begin
            ctrl[CTRL_ENABLE] <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            leds_reg <= '0;
            scratch  <= '0;
        end else if (bus_write) begin
            if (slot == ADDR_W'(REG_LEDS))    leds_reg <= merged[7:0];
            if (slot == ADDR_W'(REG_SCRATCH)) scratch  <= merged;
        end
    end

    wb_timer_core #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .enable        (ctrl[CTRL_ENABLE]),
        .auto_reload   (ctrl[CTRL_AUTO_RELOAD]),
        .reload_we     (bus_write && slot == ADDR_W'(REG_RELOAD)),
        .reload_wdata  (merged),
        .count_we      (bus_write && slot == ADDR_W'(REG_COUNT)),
        .count_wdata   (merged),
        .expired_clear (bus_write && slot == ADDR_W'(REG_STATUS) &&
                        wb.sel[0] && wb.wdata[STATUS_EXPIRED]),
        .reload        (timer_reload),
        .count         (timer_count),
        .expired       (timer_expired),
        .oneshot_stop  (oneshot_stop)
    );

    // One registered response per accepted request; reset discards it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= request & access_ok;
            err_q   <= request & ~access_ok;
            rdata_q <= (request & access_ok & ~wb.we) ? read_value : '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= timer_expired & ctrl[CTRL_IRQ_EN];
        end
    end

    assign wb.stall = 1'b0;
    assign wb.ack   = ack_q & wb.cyc;
    assign wb.err   = err_q & wb.cyc;
    assign wb.rdata = wb.ack ? rdata_q : '0;
    assign o_irq    = irq_q;

`ifdef WB_TIMER_LED_SLAVE_PWM_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pwm_duty <= 8'hFF;
            pwm_cnt  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (bus_write && slot == ADDR_W'(REG_PWM)) begin
                pwm_duty <= merged[7:0];
            end
        end
    end

    assign o_leds = leds_reg & {8{pwm_cnt < pwm_duty}};
`else
    assign o_leds = leds_reg;
`endif

endmodule

// File: tb/tb_wb_timer_led_slave.sv
// Directed bench for wb_timer_led_slave: register table plus timer/reset/bus corner sequences.
module tb_wb_timer_led_slave;

    localparam logic [29:0] BASE = 30'h0000_0010;

    typedef struct {
        string       name;
        logic        we;
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic        expAck;
        logic        expErr;
        logic [31:0] expData;
        logic [7:0]  expLeds;
    } vector_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] leds;
    logic       irq;

    int testsRun    = 0;
    int testsFailed = 0;

    vector_t vecs[$];

    wb_timer_led_slave_if bus ();

    wb_timer_led_slave #(
        .BASE_ADDR (BASE),
        .ADDR_W    (3),
        .PRESCALE  (12),
        .ID_VALUE  (32'h5742_0001)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .wb      (bus.slave),
        .o_leds  (leds),
        .o_irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Single request: drive at negedge, accepted at posedge, response sampled at next negedge.
    task automatic applyStimulus(input logic we, input logic [29:0] addr, input logic [31:0] data,
                                 input logic [3:0] sel, output logic ack, output logic err,
                                 output logic [31:0] rdata);
        @(negedge clk);
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = we;
        bus.addr  = addr;
        bus.wdata = data;
        bus.sel   = sel;
        @(posedge clk);
        @(negedge clk);
        bus.stb = 1'b0;
        bus.we  = 1'b0;
        ack     = bus.ack;
        err     = bus.err;
        rdata   = bus.rdata;
        bus.cyc = 1'b0;
    endtask

    task automatic addVec(input string name, input logic we, input logic [29:0] addr,
                          input logic [31:0] data, input logic [3:0] sel, input logic expAck,
                          input logic expErr, input logic [31:0] expData, input logic [7:0] expLeds);
        vector_t v;
        v.name = name; v.we = we; v.addr = addr; v.data = data; v.sel = sel;
        v.expAck = expAck; v.expErr = expErr; v.expData = expData; v.expLeds = expLeds;
        vecs.push_back(v);
    endtask

    task automatic busWrite(input string name, input logic [29:0] addr, input logic [31:0] data);
        logic a, e;
        logic [31:0] d;
        applyStimulus(1'b1, addr, data, 4'hF, a, e, d);
        checkOutput({name, " ack"}, {31'd0, a}, 32'd1);
    endtask

    task automatic busReadCheck(input string name, input logic [29:0] addr, input logic [31:0] expected);
        logic a, e;
        logic [31:0] d;
        applyStimulus(1'b0, addr, 32'd0, 4'h0, a, e, d);
        checkOutput({name, " ack"}, {31'd0, a}, 32'd1);
        checkOutput({name, " data"}, d, expected);
    endtask

    initial begin
        logic        a, e, sawResp, got;
        logic [31:0] d;
        int          n;

        bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.addr = '0; bus.wdata = '0; bus.sel = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset leds", {24'd0, leds}, 32'd0);
        checkOutput("reset irq", {31'd0, irq}, 32'd0);
        checkOutput("reset ack", {31'd0, bus.ack}, 32'd0);
        checkOutput("reset err", {31'd0, bus.err}, 32'd0);
        checkOutput("reset rdata", bus.rdata, 32'd0);
        checkOutput("stall", {31'd0, bus.stall}, 32'd0);
        rst = 1'b0;

        // Reset hits just after the read is accepted: its ack must never appear.
        @(negedge clk);
        bus.cyc = 1; bus.stb = 1; bus.we = 0; bus.addr = BASE + 30'd6;
        @(posedge clk);
        #1 rst = 1'b1;
        bus.stb = 0;
        @(negedge clk);
        checkOutput("ack under reset", {31'd0, bus.ack}, 32'd0);
        rst = 1'b0;
        sawResp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.ack || bus.err) sawResp = 1'b1;
        end
        checkOutput("no response after reset", {31'd0, sawResp}, 32'd0);
        bus.cyc = 0;

        addVec("rd CTRL",      0, BASE + 30'd0, 32'h0,        4'h0, 1, 0, 32'h0,        8'h00);
        addVec("rd STATUS",    0, BASE + 30'd1, 32'h0,        4'h0, 1, 0, 32'h0,        8'h00);
        addVec("rd RELOAD",    0, BASE + 30'd2, 32'h0,        4'h0, 1, 0, 32'h0,        8'h00);
        addVec("rd COUNT",     0, BASE + 30'd3, 32'h0,        4'h0, 1, 0, 32'h0,        8'h00);
        addVec("rd LEDS",      0, BASE + 30'd4, 32'h0,        4'h0, 1, 0, 32'h0,        8'h00);
        addVec("rd SCRATCH",   0, BASE + 30'd5, 32'h0,        4'h0, 1, 0, 32'h0,        8'h00);
        addVec("rd ID",        0, BASE + 30'd6, 32'h0,        4'h0, 1, 0, 32'h5742_0001, 8'h00);
        addVec("wr LEDS A5",   1, BASE + 30'd4, 32'h0000_00A5, 4'h1, 1, 0, 32'h0,       8'hA5);
        addVec("wr LEDS sel0", 1, BASE + 30'd4, 32'h0000_005A, 4'h0, 1, 0, 32'h0,       8'hA5);
        addVec("wr LEDS hi",   1, BASE + 30'd4, 32'hFFFF_FF3C, 4'hE, 1, 0, 32'h0,       8'hA5);
        addVec("rd LEDS A5",   0, BASE + 30'd4, 32'h0,        4'h0, 1, 0, 32'h0000_00A5, 8'hA5);
        addVec("wr ID",        1, BASE + 30'd6, 32'h1234_5678, 4'hF, 0, 1, 32'h0,       8'hA5);
        addVec("wr ID sel0",   1, BASE + 30'd6, 32'h1234_5678, 4'h0, 0, 1, 32'h0,       8'hA5);
        addVec("rd ID again",  0, BASE + 30'd6, 32'h0,        4'h0, 1, 0, 32'h5742_0001, 8'hA5);
        addVec("rd mismatch",  0, BASE + 30'd8, 32'h0,        4'h0, 0, 1, 32'h0,        8'hA5);
        addVec("wr mismatch",  1, BASE + 30'd12, 32'h0000_0000, 4'hF, 0, 1, 32'h0,      8'hA5);
`ifdef WB_TIMER_LED_SLAVE_PWM_EN
        addVec("rd PWM",       0, BASE + 30'd7, 32'h0,        4'h0, 1, 0, 32'h0000_00FF, 8'hA5);
`else
        addVec("rd slot7",     0, BASE + 30'd7, 32'h0,        4'h0, 0, 1, 32'h0,        8'hA5);
        addVec("wr slot7",     1, BASE + 30'd7, 32'h0000_0040, 4'hF, 0, 1, 32'h0,       8'hA5);
`endif
        addVec("wr SCRATCH",   1, BASE + 30'd5, 32'hDEAD_BEEF, 4'hF, 1, 0, 32'h0,       8'hA5);
        addVec("wr SCRATCH 5", 1, BASE + 30'd5, 32'h1122_3344, 4'h5, 1, 0, 32'h0,       8'hA5);
        addVec("rd SCRATCH",   0, BASE + 30'd5, 32'h0,        4'h0, 1, 0, 32'hDE22_BE44, 8'hA5);
        addVec("wr CTRL hi",   1, BASE + 30'd0, 32'hFFFF_FFF8, 4'hF, 1, 0, 32'h0,       8'hA5);
        addVec("rd CTRL",      0, BASE + 30'd0, 32'h0,        4'h0, 1, 0, 32'h0,        8'hA5);
        addVec("wr RELOAD",    1, BASE + 30'd2, 32'h1234_5678, 4'hC, 1, 0, 32'h0,       8'hA5);
        addVec("rd RELOAD",    0, BASE + 30'd2, 32'h0,        4'h0, 1, 0, 32'h1234_0000, 8'hA5);
        addVec("wr COUNT",     1, BASE + 30'd3, 32'h5555_CAFE, 4'h3, 1, 0, 32'h0,       8'hA5);
        addVec("rd COUNT",     0, BASE + 30'd3, 32'h0,        4'h0, 1, 0, 32'h0000_CAFE, 8'hA5);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel, a, e, d);
            checkOutput({vecs[i].name, " ack"}, {31'd0, a}, {31'd0, vecs[i].expAck});
            checkOutput({vecs[i].name, " err"}, {31'd0, e}, {31'd0, vecs[i].expErr});
            checkOutput({vecs[i].name, " data"}, d, vecs[i].expData);
            checkOutput({vecs[i].name, " leds"}, {24'd0, leds}, {24'd0, vecs[i].expLeds});
        end

        // Three back-to-back reads, one ack per request, then silence.
        @(negedge clk);
        bus.cyc = 1; bus.stb = 1; bus.we = 0; bus.addr = BASE + 30'd5;
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b ack0", {31'd0, bus.ack}, 32'd1);
        checkOutput("b2b data0", bus.rdata, 32'hDE22_BE44);
        bus.addr = BASE + 30'd6;
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b ack1", {31'd0, bus.ack}, 32'd1);
        checkOutput("b2b data1", bus.rdata, 32'h5742_0001);
        bus.addr = BASE + 30'd4;
        @(posedge clk);
        @(negedge clk);
        bus.stb = 0;
        checkOutput("b2b ack2", {31'd0, bus.ack}, 32'd1);
        checkOutput("b2b data2", bus.rdata, 32'h0000_00A5);
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b no extra ack", {31'd0, bus.ack}, 32'd0);
        bus.cyc = 0;

        // Master drops cyc in the response cycle: the ack is lost.
        @(negedge clk);
        bus.cyc = 1; bus.stb = 1; bus.we = 0; bus.addr = BASE + 30'd6;
        @(posedge clk);
        #1 bus.cyc = 0; bus.stb = 0;
        @(negedge clk);
        checkOutput("dropped ack", {31'd0, bus.ack}, 32'd0);
        bus.cyc = 1;
        @(negedge clk);
        checkOutput("dropped ack late", {31'd0, bus.ack}, 32'd0);
        bus.cyc = 0;

        // Auto-reload: 3 -> 0 then expire takes 4 ticks of 12 clocks, irq one clock later.
        busWrite("wr RELOAD 3", BASE + 30'd2, 32'd3);
        busWrite("wr COUNT 3", BASE + 30'd3, 32'd3);
        busWrite("wr CTRL 7", BASE + 30'd0, 32'd7);
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (irq) got = 1'b1;
        end
        checkOutput("irq latency", n, 49);
        busReadCheck("rd COUNT reloaded", BASE + 30'd3, 32'd3);
        busReadCheck("rd STATUS expired", BASE + 30'd1, 32'd1);
        checkOutput("irq held", {31'd0, irq}, 32'd1);
        busWrite("wr CTRL 0", BASE + 30'd0, 32'd0);
        busWrite("w1c STATUS", BASE + 30'd1, 32'd1);
        busReadCheck("rd STATUS cleared", BASE + 30'd1, 32'd0);
        checkOutput("irq cleared", {31'd0, irq}, 32'd0);

        // One-shot from zero; a W1C landing on the expiry edge must lose.
        busWrite("wr COUNT 0", BASE + 30'd3, 32'd0);
        busWrite("wr CTRL 1", BASE + 30'd0, 32'd1);
        repeat (11) @(posedge clk);
        busWrite("w1c on set", BASE + 30'd1, 32'd1);
        busReadCheck("rd STATUS set wins", BASE + 30'd1, 32'd1);
        busReadCheck("rd CTRL one-shot off", BASE + 30'd0, 32'd0);
        busReadCheck("rd COUNT one-shot", BASE + 30'd3, 32'd0);
        checkOutput("irq masked", {31'd0, irq}, 32'd0);
        busWrite("w1c alone", BASE + 30'd1, 32'd1);
        repeat (30) @(posedge clk);
        busReadCheck("rd STATUS stopped", BASE + 30'd1, 32'd0);

`ifdef WB_TIMER_LED_SLAVE_PWM_EN
        busWrite("wr PWM 40", BASE + 30'd7, 32'h40);
        busWrite("wr LEDS FF", BASE + 30'd4, 32'hFF);
        n = 0;
        repeat (256) begin
            @(negedge clk);
            if (leds == 8'hFF) n++;
        end
        checkOutput("pwm high count", n, 64);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
